display_refresh_ctrl: RTL and testbench
=======================================

# display_refresh_ctrl

Frame sequencer for the clock's serial 7-segment output path. On a refresh request it snapshots NUM_DIGITS BCD digits plus decimal-point mask and decodes each to a segment byte. It then drives the shared 8-bit serial shift-register block one byte per transfer using its start/busy handshake, and pulses the external display latch once the whole frame is shifted. It also generates the serial-rate clock strobe consumed by the shift register.

## Interface
- NUM_DIGITS, 4: digits per frame (1–8).
- CLK_DIV, 4: i_clk cycles per o_sr_clk_stb pulse (≥2).
- COMMON_ANODE, 0: 1 inverts every segment byte before output.
- i_clk  in  1  system clock.
- i_reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_refresh_stb  in  1  one-cycle request to send a new frame.
- i_digits  in  4*NUM_DIGITS  BCD digits; digit k = i_digits[4k+3:4k].
- i_dp_mask  in  NUM_DIGITS  bit k lights decimal point of digit k.
- i_sr_busy  in  1  shift register busy.
- o_sr_start_stb  out  1  one-cycle transfer start to shift register.
- o_sr_data  out  8  byte to shift, {dp,g,f,e,d,c,b,a}.
- o_sr_clk_stb  out  1  serial-rate strobe to shift register.
- o_latch  out  1  external display latch enable.
- o_busy  out  1  frame in progress (state ≠ IDLE).
- o_frame_done_stb  out  1  one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, WAIT_ACK, WAIT_DONE, LATCH.
- IDLE: on i_refresh_stb or pending flag, register i_digits/i_dp_mask into snapshot, digit index := NUM_DIGITS-1, clear pending, go START.
- START: o_sr_start_stb=1 for this cycle only; o_sr_data = decoded byte of current index; go WAIT_ACK.
- WAIT_ACK: hold o_sr_data; go WAIT_DONE when i_sr_busy=1.
- WAIT_DONE: hold o_sr_data; when i_sr_busy=0: if index=0 go LATCH, else index−1 and go START.
- LATCH: o_latch=1; exit to IDLE on the second o_sr_clk_stb pulse seen in LATCH; o_frame_done_stb=1 on that exit cycle.
- Digits sent highest index first. BCD 0–9 → standard active-high patterns (0=0x3F,1=0x06,2=0x5B,3=0x4F,4=0x66,5=0x6D,6=0x7D,7=0x07,8=0x7F,9=0x6F); 10–15 → 0x00 (blank). Bit 7 = dp mask bit. COMMON_ANODE inverts all 8 bits after dp merge.
- i_refresh_stb while not IDLE (including the LATCH exit cycle) sets pending. Further requests coalesce into one. The pending frame samples inputs at its own start, not at request time.
- Divider: counter 0..CLK_DIV-1, free-running from reset; o_sr_clk_stb=1 when counter = CLK_DIV-1.

## Timing
- All outputs registered. Reset values: o_sr_start_stb=0, o_sr_data=0x00, o_sr_clk_stb=0, o_latch=0, o_busy=0, o_frame_done_stb=0; state IDLE, pending 0, divider 0.
- Strobe at cycle n in IDLE → o_busy=1 and o_sr_start_stb=1 at n+1.
- o_sr_data is valid the same cycle as o_sr_start_stb and is stable until WAIT_DONE exits.
- No new start while i_sr_busy=1. The shift register raises busy the cycle after start.
- Minimum gap between consecutive frames: 1 IDLE cycle.
- Asynchronous reset mid-frame aborts immediately: o_latch drops, and the partial frame is discarded with no done pulse.

## Structure
- Shared package clock_display_pkg: state encoding localparams, the 7-segment pattern constants, and the segment bit-order definition.
- Sub-module bcd_to_7seg: combinational 4-bit BCD → 7-bit segments, reused by other display paths.
- Controller FSM, index counter, pending flag and divider live in this block.

## Test plan
- i_digits=16'h1234, mask 0 → starts carry bytes 0x06,0x5B,0x4F,0x66 in order; one latch window; one o_frame_done_stb.
- i_dp_mask=4'b0100, digits 16'h1234 → second byte 0xDB; others unchanged. COMMON_ANODE=1 build → first byte 0xF9.
- Digit value 4'hA at index 0 → last byte 0x00.
- Three i_refresh_stb during a frame, with digits changed to 16'h5678 before completion → exactly one extra frame follows, sending 0x6D,0x7D,0x07,0x7F.
- Shift register model holding busy for 100 cycles → no second start until busy falls. o_sr_data is stable throughout.
- Reset asserted in WAIT_DONE of digit 2 → all outputs 0 asynchronously. After release, o_sr_clk_stb first pulses CLK_DIV cycles later, with no spurious latch or done pulse.

Source files
------------

// File: rtl/clock_display_pkg.sv
// rtl/clock_display_pkg.sv - shared types and segment constants for the clock display paths
package clock_display_pkg;

  // Controller state encodings
  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_START     = 3'd1;
  localparam logic [2:0] ENC_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ENC_WAIT_DONE = 3'd3;
  localparam logic [2:0] ENC_LATCH     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_START     = ENC_START,
    ST_WAIT_ACK  = ENC_WAIT_ACK,
    ST_WAIT_DONE = ENC_WAIT_DONE,
    ST_LATCH     = ENC_LATCH
  } ctrl_state_e;

  // Bit order of a segment byte as it leaves on the serial line: bit 0 = a
  typedef struct packed {
    logic dp;
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_byte_t;

  // Active-high patterns, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0] SEG_PAT_0  = 7'h3F;
  localparam logic [6:0] SEG_PAT_1  = 7'h06;
  localparam logic [6:0] SEG_PAT_2  = 7'h5B;
  localparam logic [6:0] SEG_PAT_3  = 7'h4F;
  localparam logic [6:0] SEG_PAT_4  = 7'h66;
  localparam logic [6:0] SEG_PAT_5  = 7'h6D;
  localparam logic [6:0] SEG_PAT_6  = 7'h7D;
  localparam logic [6:0] SEG_PAT_7  = 7'h07;
  localparam logic [6:0] SEG_PAT_8  = 7'h7F;
  localparam logic [6:0] SEG_PAT_9  = 7'h6F;
  localparam logic [6:0] SEG_BLANK  = 7'h00;

  // Merge the decimal point into a segment byte; inversion applies to all 8 bits
  function automatic logic [7:0] seg_byte(input logic [6:0] seg, input logic dp,
                                          input logic invert);
    seg_byte_t s;
    s = seg_byte_t'({dp, seg});
    return invert ? ~s : s;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD digit to active-high 7-segment pattern
module bcd_to_7seg
  import clock_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Codes 10..15 are not decimal digits and show as blank
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_PAT_0;
      4'd1:    seg_o = SEG_PAT_1;
      4'd2:    seg_o = SEG_PAT_2;
      4'd3:    seg_o = SEG_PAT_3;
      4'd4:    seg_o = SEG_PAT_4;
      4'd5:    seg_o = SEG_PAT_5;
      4'd6:    seg_o = SEG_PAT_6;
      4'd7:    seg_o = SEG_PAT_7;
      4'd8:    seg_o = SEG_PAT_8;
      4'd9:    seg_o = SEG_PAT_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_refresh_ctrl.sv
// rtl/display_refresh_ctrl.sv - frame sequencer feeding the serial 7-segment shift register
module display_refresh_ctrl
  import clock_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 4,
  parameter int COMMON_ANODE = 0
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_refresh_stb,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_dp_mask,
  input  logic                    i_sr_busy,
  output logic                    o_sr_start_stb,
  output logic [7:0]              o_sr_data,
  output logic                    o_sr_clk_stb,
  output logic                    o_latch,
  output logic                    o_busy,
  output logic                    o_frame_done_stb
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic             INVERT   = (COMMON_ANODE != 0);

  ctrl_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    lstb_seen_q, lstb_seen_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    clk_stb_q;

  logic                    start_q, start_d;
  logic [7:0]              data_q, data_d;
  logic                    latch_q, latch_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [3:0]              sel_bcd;
  logic                    sel_dp;
  logic [6:0]              sel_seg;

  // Free-running serial-rate divider, wraps at CLK_DIV-1
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  // Divider register; the strobe is high exactly while the counter sits at CLK_DIV-1
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      div_q     <= '0;
      clk_stb_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      clk_stb_q <= (div_d == DIV_LAST);
    end
  end

  // Next state, snapshot, digit index, pending request and latch strobe tracking
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    digits_d    = digits_q;
    dp_d        = dp_q;
    lstb_seen_d = lstb_seen_q;
    done_d      = 1'b0;

    // Requests arriving mid-frame coalesce into a single follow-up frame
    if (state_q != ST_IDLE && i_refresh_stb) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_refresh_stb || pending_q) begin
          digits_d  = i_digits;
          dp_d      = i_dp_mask;
          idx_d     = IDX_LAST;
          pending_d = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (i_sr_busy) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!i_sr_busy) begin
          if (idx_q == '0) begin
            lstb_seen_d = 1'b0;
            state_d     = ST_LATCH;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = ST_START;
          end
        end
      end
      ST_LATCH: begin
        // Hold the latch until the second serial strobe observed in this state
        if (clk_stb_q) begin
          if (lstb_seen_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            lstb_seen_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pick the digit and dp bit that the next START will transmit
  always_comb begin
    sel_bcd = digits_d[{idx_d, 2'b00} +: 4];
    sel_dp  = dp_d[idx_d];
  end

  bcd_to_7seg u_bcd_to_7seg (
    .bcd_i (sel_bcd),
    .seg_o (sel_seg)
  );

  // Output next values, decoded from the upcoming state so every output is a flop
  always_comb begin
    start_d = (state_d == ST_START);
    latch_d = (state_d == ST_LATCH);
    busy_d  = (state_d != ST_IDLE);
    data_d  = data_q;
    if (state_d == ST_START) begin
      data_d = seg_byte(sel_seg, sel_dp, INVERT);
    end
  end

  // Controller and output registers; reset aborts any frame in flight
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      digits_q    <= '0;
      dp_q        <= '0;
      lstb_seen_q <= 1'b0;
      start_q     <= 1'b0;
      data_q      <= 8'h00;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      lstb_seen_q <= lstb_seen_d;
      start_q     <= start_d;
      data_q      <= data_d;
      latch_q     <= latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_sr_start_stb   = start_q;
  assign o_sr_data        = data_q;
  assign o_sr_clk_stb     = clk_stb_q;
  assign o_latch          = latch_q;
  assign o_busy           = busy_q;
  assign o_frame_done_stb = done_q;

endmodule

// File: tb/tb_display_refresh_ctrl.sv
// tb/tb_display_refresh_ctrl.sv - self-checking bench for display_refresh_ctrl
module tb_display_refresh_ctrl;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b0;
  logic           refresh = 1'b0;
  logic [4*N-1:0] digits  = '0;
  logic [N-1:0]   dp      = '0;
  logic           sr_busy = 1'b0;

  logic       start, stb, latch, busy, done;
  logic [7:0] data;
  logic       ca_start, ca_stb, ca_latch, ca_busy, ca_done;
  logic [7:0] ca_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int latch_windows = 0;
  int win_stb = 0;
  int hold_min = 1;
  int hold_max = 4;
  int busy_left = 0;
  logic start_seen = 1'b0;
  logic prev_latch = 1'b0;
  logic prev_stb = 1'b0;
  logic [7:0] xfer_byte = 8'h00;
  logic [7:0] got_q[$];
  logic [7:0] got_ca_q[$];
  logic [7:0] exp_q[$];

  logic [6:0] pat_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  always #5 clk = ~clk;

  display_refresh_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .COMMON_ANODE(0)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_refresh_stb(refresh), .i_digits(digits),
    .i_dp_mask(dp), .i_sr_busy(sr_busy), .o_sr_start_stb(start), .o_sr_data(data),
    .o_sr_clk_stb(stb), .o_latch(latch), .o_busy(busy), .o_frame_done_stb(done)
  );

  display_refresh_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .COMMON_ANODE(1)) dut_ca (
    .i_clk(clk), .i_reset_n(rst_n), .i_refresh_stb(refresh), .i_digits(digits),
    .i_dp_mask(dp), .i_sr_busy(sr_busy), .o_sr_start_stb(ca_start), .o_sr_data(ca_data),
    .o_sr_clk_stb(ca_stb), .o_latch(ca_latch), .o_busy(ca_busy), .o_frame_done_stb(ca_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Clock edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc = 0;
    else cyc = cyc + 1;
  end

  // Shift register model: busy rises the cycle after a start and stays for a hold time
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_busy   = 1'b0;
      busy_left = 0;
    end else begin
      #1;
      if (start_seen) begin
        sr_busy   = 1'b1;
        busy_left = int'($urandom_range(hold_max, hold_min));
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) sr_busy = 1'b0;
      end
    end
  end

  // Protocol monitor and byte collector
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_latch = 1'b0;
      prev_stb   = 1'b0;
      start_seen = 1'b0;
    end else begin
      start_seen = start;
      chk("divider_phase", 32'(stb), 32'((cyc % DIV) == DIV - 1));
      chk("ca_ctrl_match", 32'({ca_start, ca_stb, ca_latch, ca_busy, ca_done}),
          32'({start, stb, latch, busy, done}));
      if (start) begin
        start_cnt++;
        chk("no_start_while_busy", 32'(sr_busy), 32'd0);
        chk("ca_data_inverted", 32'(ca_data ^ data), 32'hFF);
        got_q.push_back(data);
        got_ca_q.push_back(ca_data);
        xfer_byte = data;
      end
      if (sr_busy) chk("data_stable_while_busy", 32'(data), 32'(xfer_byte));
      if (latch && !prev_latch) begin
        latch_windows++;
        win_stb = 0;
      end
      if (latch && stb) win_stb++;
      if (done) begin
        done_cnt++;
        chk("done_at_latch_fall", 32'({prev_latch, latch, busy}), 32'h4);
        chk("latch_window_stb_pulses", 32'(win_stb), 32'd2);
        chk("latch_exit_on_stb", 32'(prev_stb), 32'd1);
      end
      prev_latch = latch;
      prev_stb   = stb;
    end
  end

  task automatic add_exp(input logic [4*N-1:0] dg, input logic [N-1:0] m);
    for (int k = N - 1; k >= 0; k--) exp_q.push_back({m[k], pat_tbl[dg[4*k +: 4]]});
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_byte_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        chk({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_ca_byte"}, 32'(got_ca_q[i]), 32'(exp_q[i] ^ 8'hFF));
      end
    end
    got_q.delete();
    got_ca_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_before_frame", 32'(busy), 32'd0);
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic run_frame(input logic [4*N-1:0] dg, input logic [N-1:0] m, input string tag);
    int base_done = done_cnt;
    int base_lw   = latch_windows;
    wait_idle();
    @(negedge clk);
    digits  = dg;
    dp      = m;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    chk({tag, "_start_latency"}, 32'({busy, start}), 32'h3);
    wait_done(tag);
    repeat (3 * DIV) @(negedge clk);
    chk({tag, "_one_done"}, 32'(done_cnt - base_done), 32'd1);
    chk({tag, "_one_latch"}, 32'(latch_windows - base_lw), 32'd1);
    add_exp(dg, m);
    check_frames(tag);
  endtask

  initial begin
    int base_done;
    int base_start;
    int base_lw;
    int t;

    // Reset state
    #1;
    chk("reset_outputs", 32'({start, data, stb, latch, busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frames
    hold_min = 1; hold_max = 4;
    run_frame(16'h1234, 4'b0000, "plain_1234");
    run_frame(16'h1234, 4'b0100, "dp_1234");
    run_frame(16'h123A, 4'b0000, "blank_idx0");
    run_frame(16'hFFFF, 4'b1111, "all_blank_dp");

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      logic [4*N-1:0] dg;
      logic [N-1:0]   m;
      dg = 16'($urandom);
      m  = 4'($urandom);
      hold_max = 1 + r;
      run_frame(dg, m, "random");
    end

    // Three requests mid-frame coalesce into one follow-up frame that samples late inputs
    hold_min = 3; hold_max = 5;
    wait_idle();
    base_done  = done_cnt;
    base_start = start_cnt;
    @(negedge clk);
    digits = 16'h1234; dp = 4'b0000; refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    repeat (3) @(negedge clk);
    pulse_refresh();
    repeat (2) @(negedge clk);
    pulse_refresh();
    pulse_refresh();
    digits = 16'h5678;
    wait_done("coalesce_first");
    @(negedge clk);
    chk("coalesce_gap_one_idle", 32'({busy, start}), 32'h3);
    wait_done("coalesce_second");
    repeat (60) @(negedge clk);
    chk("coalesce_two_frames", 32'(done_cnt - base_done), 32'd2);
    chk("coalesce_eight_starts", 32'(start_cnt - base_start), 32'd8);
    add_exp(16'h1234, 4'b0000);
    add_exp(16'h5678, 4'b0000);
    check_frames("coalesce");

    // Long busy from the shift register
    hold_min = 100; hold_max = 100;
    run_frame(16'h9870, 4'b0001, "long_busy");

    // Asynchronous reset while digit 2 is in flight
    hold_min = 3; hold_max = 5;
    wait_idle();
    base_done  = done_cnt;
    base_start = start_cnt;
    base_lw    = latch_windows;
    @(negedge clk);
    digits = 16'h4321; dp = 4'b1111; refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    t = 0;
    while (start_cnt < base_start + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    while (!sr_busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_reached_digit2", 32'(sr_busy), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({start, data, stb, latch, busy, done}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    chk("reset_no_restart", 32'(start_cnt - base_start), 32'd2);
    chk("reset_no_done", 32'(done_cnt - base_done), 32'd0);
    chk("reset_no_latch", 32'(latch_windows - base_lw), 32'd0);
    got_q.delete();
    got_ca_q.delete();

    // Recovery after reset
    run_frame(16'h0905, 4'b1010, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
